dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the beta core's load/store port: services memAddr/MemRead/MemWrite
//  with word-addressed RAM plus a small memory-mapped timer that drives the core's irq input.
//  Sits beside beta at top level. Reads are combinational to match beta's single-cycle datapath.
//  Writes commit on the rising clock edge.
// PARAMETERS
//  DEPTH      256            RAM size in 32-bit words (power of 2); RAM decodes byte addr [DEPTH*4-1:0]
//  MMIO_BASE  32'hFFFF_FF00  base byte address of the 16-byte timer register window
// PORTS
//  clk           in   1   system clock, single domain
//  reset         in   1   synchronous, active-high reset
//  memAddr       in   32  byte address from beta (ALU result)
//  memWriteData  in   32  store data from beta
//  MemRead       in   1   load strobe
//  MemWrite      in   1   store strobe
//  memReadData   out  32  load data, combinational from memAddr
//  irq           out  1   timer interrupt to beta, registered-state derived
//  bus_err       out  1   combinational flag: current access is unmapped or misaligned
// BEHAVIOUR
//  - Decode by memAddr: RAM if memAddr < DEPTH*4; TIMER if memAddr[31:4]==MMIO_BASE[31:4]; else UNMAPPED.
//  - Misaligned accesses (memAddr[1:0]!=0) and UNMAPPED accesses behave the same way:
//    - reads return 32'd0; writes are dropped;
//    - bus_err = (MemRead|MemWrite) for that access.
//  - RAM: word index memAddr[$clog2(DEPTH)+1:2].
//    - Write: on posedge when MemWrite. Read-after-write to the same word returns the new value next cycle.
//    - Contents are not cleared by reset.
//  - memReadData: 0 when MemRead=0. With MemRead=1, RAM data or timer register value.
//  - MemRead&MemWrite together: the write commits. memReadData shows the pre-write value that cycle.
//  - Timer registers, offsets from MMIO_BASE:
//    - 0x0 TCTRL  [0]=en [1]=irq_en [2]=autoreload, rest RAZ/WI
//    - 0x4 TCOUNT  R/W
//    - 0x8 TCMP  R/W
//    - 0xC TSTAT  [0]=pending, write-1-to-clear
//  - Count: each cycle with en=1, TCOUNT <= TCOUNT+1 mod 2^32 (wraps 0xFFFF_FFFF->0).
//  - Match: when en=1 and TCOUNT==TCMP, pending <= 1 on the next edge.
//    - If autoreload=1, TCOUNT <= 0 on that edge instead of incrementing.
//  - Priority, same cycle:
//    - CPU write to TCOUNT beats increment and autoreload.
//    - Match-set of pending beats W1C of pending.
//    - A TCTRL write takes effect from the next cycle.
//  - irq = pending & irq_en (combinational from flops). Stays high until cleared or irq_en=0.
//  - Reset: TCTRL=0, TCOUNT=0, TCMP=0, pending=0 -> irq=0. bus_err and memReadData are combinational.
//    Reset mid-count discards the count. A store coincident with reset is still applied to RAM.
// CONFIGURATION
//  - DMEM_TIMER_EN defined: timer block as above.
//  - DMEM_TIMER_EN undefined: no timer flops; timer window decodes as UNMAPPED
//    (reads 0, writes dropped, bus_err asserted); irq tied 0.
// STRUCTURE
//  - beta_mem_pkg: MMIO offset constants (TCTRL_OFF..TSTAT_OFF), TCTRL bit indices,
//    region enum {REG_RAM, REG_TIMER, REG_UNMAPPED}.
//  - Sub-module dmem_timer holds the four timer registers, the counter and the irq logic.
//    The top level keeps address decode, the RAM array and the read mux.
// TESTING
//  1. sw 0xDEADBEEF @0x10, next cycle lw @0x10 -> 0xDEADBEEF.
//     lw @0x14 -> 0 after a preload of 0. bus_err=0 throughout.
//  2. lw @0x12 or sw @0x12 (misaligned) -> memReadData=0, bus_err=1, RAM word 0x10 unchanged.
//     lw @0x8000_0000 -> 0, bus_err=1.
//  3. TCMP=5, TCTRL=0x3 -> pending and irq rise 6 cycles after enable (count 0..5, then match edge).
//     Write 1 to TSTAT clears irq. TCOUNT keeps counting.
//  4. TCMP=3, TCTRL=0x7 -> TCOUNT sequence 0,1,2,3,0,1...
//     Coincident W1C at the match cycle -> pending stays 1.
//  5. TCOUNT=0xFFFF_FFFE, en=1 -> reads 0xFFFF_FFFF, then 0x0 (wrap).
//     A TCOUNT write of 0x100 while counting -> next read 0x100.
//  6. Assert reset mid-count with irq=1 -> next cycle irq=0, TCOUNT=0, and RAM data is retained.
//     Build without DMEM_TIMER_EN -> MMIO_BASE+4 reads 0, bus_err=1, irq never asserts.

Source files
------------

// File: rtl/beta_mem_pkg.sv
// Shared constants for the beta data-memory responder:
// timer register offsets, TCTRL bit positions and the address-region enum.
package beta_mem_pkg;

  localparam logic [3:0] TCTRL_OFF  = 4'h0;
  localparam logic [3:0] TCOUNT_OFF = 4'h4;
  localparam logic [3:0] TCMP_OFF   = 4'h8;
  localparam logic [3:0] TSTAT_OFF  = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_TIMER,
    REG_UNMAPPED
  } region_e;

endpackage

// File: rtl/dmem_timer.sv
// Memory-mapped timer: TCTRL/TCOUNT/TCMP/TSTAT, compare-match pending flag and irq.
// Only instantiated when DMEM_TIMER_EN is defined.
module dmem_timer
  import beta_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_i,
  input  logic [3:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              pend_q, pend_d;
  logic              match;
  logic              wr_ctrl, wr_count;
  logic              wr_cmp, wr_stat;

  always_comb begin
    wr_ctrl  = 1'b0;
    wr_count = 1'b0;
    wr_cmp   = 1'b0;
    wr_stat  = 1'b0;
    if (wr_i) begin
      unique case (off_i)
        TCTRL_OFF:  wr_ctrl  = 1'b1;
        TCOUNT_OFF: wr_count = 1'b1;
        TCMP_OFF:   wr_cmp   = 1'b1;
        TSTAT_OFF:  wr_stat  = 1'b1;
        default: ;
      endcase
    end
  end

  assign match = ctrl_q[CTRL_EN] && (count_q == cmp_q);

  // CPU write to TCOUNT wins over reload and increment;
  // a match wins over a same-cycle clear.
  always_comb begin
    ctrl_d  = wr_ctrl ? wdata_i[CTRL_W-1:0] : ctrl_q;
    cmp_d   = wr_cmp ? wdata_i : cmp_q;
    count_d = count_q;
    if (wr_count)
      count_d = wdata_i;
    else if (match && ctrl_q[CTRL_AUTO])
      count_d = '0;
    else if (ctrl_q[CTRL_EN])
      count_d = count_q + 32'd1;
    pend_d = pend_q;
    if (match)
      pend_d = 1'b1;
    else if (wr_stat && wdata_i[0])
      pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (off_i)
      TCTRL_OFF:  rdata_o = {{(32-CTRL_W){1'b0}}, ctrl_q};
      TCOUNT_OFF: rdata_o = count_q;
      TCMP_OFF:   rdata_o = cmp_q;
      TSTAT_OFF:  rdata_o = {31'd0, pend_q};
      default: ;
    endcase
  end

  assign irq_o = pend_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for beta: word RAM, combinational reads, optional timer.
// Define DMEM_TIMER_EN to build the timer; otherwise its window is unmapped.
module dmem_responder
  import beta_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] memReadData,
  output logic        irq,
  output logic        bus_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 2;

  logic [31:0]   mem_q [DEPTH];
  region_e       region;
  logic          misal;
  logic          ok;
  logic [IW-1:0] idx;
  logic          ram_we;
  logic [31:0]   tmr_rdata;

  always_comb begin
    region = REG_UNMAPPED;
    if (memAddr[31:AW] == '0)
      region = REG_RAM;
`ifdef DMEM_TIMER_EN
    else if (memAddr[31:4] == MMIO_BASE[31:4])
      region = REG_TIMER;
`endif
  end

  assign misal   = memAddr[1:0] != 2'b00;
  assign ok      = !misal && (region != REG_UNMAPPED);
  assign bus_err = (MemRead | MemWrite) && !ok;
  assign idx     = memAddr[AW-1:2];
  assign ram_we  = MemWrite && ok && (region == REG_RAM);

  // No reset: RAM contents survive reset, including a coincident store.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem_q[idx] <= memWriteData;
  end

  always_comb begin
    memReadData = '0;
    if (MemRead && ok) begin
      unique case (region)
        REG_RAM:   memReadData = mem_q[idx];
        REG_TIMER: memReadData = tmr_rdata;
        default: ;
      endcase
    end
  end

`ifdef DMEM_TIMER_EN
  logic tmr_wr;

  assign tmr_wr = MemWrite && ok && (region == REG_TIMER);

  dmem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (tmr_wr),
    .off_i   (memAddr[3:0]),
    .wdata_i (memWriteData),
    .rdata_o (tmr_rdata),
    .irq_o   (irq)
  );
`else
  logic unused_reset;

  assign unused_reset = reset;
  assign tmr_rdata    = '0;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: RAM, bus errors, timer (or its absence), reset.
// Timer scenarios compile only when DMEM_TIMER_EN is defined.
module tb_dmem_responder;

  localparam logic [31:0] TB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memAddr = '0;
  logic [31:0] memWriteData = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] memReadData;
  logic        irq;
  logic        bus_err;

  dmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .memReadData  (memReadData),
    .irq          (irq),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [31:0] a;
    logic [31:0] wd;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic        e;
    logic        i;
  } op_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        i;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic op_t rd(input logic [31:0] a, input logic [31:0] d,
                             input logic e, input logic i);
    op_t o;
    o.rst = 1'b0; o.a = a; o.wd = '0; o.r = 1'b1; o.w = 1'b0;
    o.d = d; o.e = e; o.i = i;
    return o;
  endfunction

  function automatic op_t wr(input logic [31:0] a, input logic [31:0] wd,
                             input logic e, input logic i);
    op_t o;
    o.rst = 1'b0; o.a = a; o.wd = wd; o.r = 1'b0; o.w = 1'b1;
    o.d = '0; o.e = e; o.i = i;
    return o;
  endfunction

  function automatic op_t nop(input logic i);
    op_t o;
    o.rst = 1'b0; o.a = 32'h10; o.wd = '0; o.r = 1'b0; o.w = 1'b0;
    o.d = '0; o.e = 1'b0; o.i = i;
    return o;
  endfunction

  task automatic apply(input op_t o);
    exp_t x;
    reset = o.rst;
    memAddr = o.a;
    memWriteData = o.wd;
    MemRead = o.r;
    MemWrite = o.w;
    x.d = o.d; x.e = o.e; x.i = o.i;
    sb.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    op_t o;
    o = nop(1'b0);
    o.rst = 1'b1;
    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    op_t  ops[$];
    exp_t x;
    op_t  o;
    reset = 1'b1;
    tick;
    o = nop(1'b0);
    o.rst = 1'b1;
    ops.push_back(o);
    ops.push_back(nop(1'b0));
`ifdef DMEM_TIMER_EN
    for (int k = 0; k < 4; k++)
      ops.push_back(rd(TB + 32'(4 * k), 32'd0, 1'b0, 1'b0));
`endif
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL reset[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
    reset = 1'b0;
  endtask

  task automatic test_ram;
    op_t         ops[$];
    exp_t        x;
    op_t         o;
    logic [31:0] v [8];
    ops.push_back(wr(32'h14, 32'h0, 1'b0, 1'b0));
    ops.push_back(wr(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0));
    ops.push_back(rd(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0));
    ops.push_back(rd(32'h14, 32'h0, 1'b0, 1'b0));
    o = rd(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    o.w = 1'b1;
    o.wd = 32'h1234_5678;
    ops.push_back(o);
    ops.push_back(rd(32'h10, 32'h1234_5678, 1'b0, 1'b0));
    ops.push_back(nop(1'b0));
    ops.push_back(wr(32'h3FC, 32'hA5A5_5A5A, 1'b0, 1'b0));
    ops.push_back(rd(32'h3FC, 32'hA5A5_5A5A, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      v[k] = $urandom;
      ops.push_back(wr(32'h100 + 32'(4 * k), v[k], 1'b0, 1'b0));
    end
    for (int k = 7; k >= 0; k--)
      ops.push_back(rd(32'h100 + 32'(4 * k), v[k], 1'b0, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL ram[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask

  task automatic test_bus_err;
    op_t  ops[$];
    exp_t x;
    op_t  o;
    ops.push_back(rd(32'h12, 32'h0, 1'b1, 1'b0));
    ops.push_back(wr(32'h12, 32'hFFFF_FFFF, 1'b1, 1'b0));
    ops.push_back(rd(32'h10, 32'h1234_5678, 1'b0, 1'b0));
    ops.push_back(rd(32'h3FD, 32'h0, 1'b1, 1'b0));
    ops.push_back(rd(32'h8000_0000, 32'h0, 1'b1, 1'b0));
    ops.push_back(wr(32'h0, 32'h1111_1111, 1'b0, 1'b0));
    ops.push_back(wr(32'h400, 32'hAAAA_AAAA, 1'b1, 1'b0));
    ops.push_back(rd(32'h0, 32'h1111_1111, 1'b0, 1'b0));
    ops.push_back(rd(32'h400, 32'h0, 1'b1, 1'b0));
    o = nop(1'b0);
    o.a = 32'h8000_0002;
    ops.push_back(o);
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL bus_err[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer_irq;
    op_t  ops[$];
    exp_t x;
    do_reset;
    ops.push_back(rd(TB + 32'h2, 32'h0, 1'b1, 1'b0));
    ops.push_back(wr(TB + 32'h8, 32'd5, 1'b0, 1'b0));
    ops.push_back(wr(TB + 32'h0, 32'h3, 1'b0, 1'b0));
    for (int n = 0; n < 8; n++)
      ops.push_back(rd(TB + 32'h4, 32'(n), 1'b0, n >= 6));
    ops.push_back(wr(TB + 32'hC, 32'h1, 1'b0, 1'b1));
    ops.push_back(rd(TB + 32'hC, 32'h0, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'd10, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h0, 32'h3, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h8, 32'd5, 1'b0, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL timer_irq[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask

  task automatic test_autoreload;
    op_t  ops[$];
    exp_t x;
    do_reset;
    ops.push_back(wr(TB + 32'h8, 32'd3, 1'b0, 1'b0));
    ops.push_back(wr(TB + 32'h0, 32'h7, 1'b0, 1'b0));
    for (int n = 0; n < 8; n++)
      ops.push_back(rd(TB + 32'h4, 32'(n % 4), 1'b0, n >= 4));
    ops.push_back(wr(TB + 32'hC, 32'h1, 1'b0, 1'b1));
    ops.push_back(rd(TB + 32'hC, 32'h0, 1'b0, 1'b0));
    ops.push_back(nop(1'b0));
    ops.push_back(wr(TB + 32'hC, 32'h1, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'hC, 32'h1, 1'b0, 1'b1));
    ops.push_back(wr(TB + 32'h0, 32'h5, 1'b0, 1'b1));
    ops.push_back(rd(TB + 32'hC, 32'h1, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'd3, 1'b0, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL autoreload[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    op_t  ops[$];
    exp_t x;
    do_reset;
    ops.push_back(wr(TB + 32'h4, 32'hFFFF_FFFE, 1'b0, 1'b0));
    ops.push_back(wr(TB + 32'h0, 32'h1, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'hFFFF_FFFE, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'h0, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'h1, 1'b0, 1'b0));
    ops.push_back(wr(TB + 32'h4, 32'h100, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'h100, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h4, 32'h101, 1'b0, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL wrap[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask
`else
  task automatic test_no_timer;
    op_t  ops[$];
    exp_t x;
    ops.push_back(rd(TB + 32'h4, 32'h0, 1'b1, 1'b0));
    ops.push_back(wr(TB + 32'h8, 32'h0, 1'b1, 1'b0));
    ops.push_back(wr(TB + 32'h0, 32'h3, 1'b1, 1'b0));
    ops.push_back(rd(TB + 32'h0, 32'h0, 1'b1, 1'b0));
    for (int n = 0; n < 10; n++)
      ops.push_back(nop(1'b0));
    ops.push_back(rd(TB + 32'hC, 32'h0, 1'b1, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL no_timer[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
  endtask
`endif

  task automatic test_reset_mid;
    op_t  ops[$];
    exp_t x;
    op_t  o;
    logic hot;
    do_reset;
    ops.push_back(wr(32'h20, 32'hCAFE_F00D, 1'b0, 1'b0));
`ifdef DMEM_TIMER_EN
    hot = 1'b1;
    ops.push_back(wr(TB + 32'h8, 32'd2, 1'b0, 1'b0));
    ops.push_back(wr(TB + 32'h0, 32'h3, 1'b0, 1'b0));
    ops.push_back(nop(1'b0));
    ops.push_back(nop(1'b0));
    ops.push_back(nop(1'b0));
    ops.push_back(nop(1'b1));
`else
    hot = 1'b0;
`endif
    o = wr(32'h24, 32'h5555_AAAA, 1'b0, hot);
    o.rst = 1'b1;
    ops.push_back(o);
    ops.push_back(nop(1'b0));
`ifdef DMEM_TIMER_EN
    ops.push_back(rd(TB + 32'h4, 32'h0, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'h0, 32'h0, 1'b0, 1'b0));
    ops.push_back(rd(TB + 32'hC, 32'h0, 1'b0, 1'b0));
`endif
    ops.push_back(rd(32'h20, 32'hCAFE_F00D, 1'b0, 1'b0));
    ops.push_back(rd(32'h24, 32'h5555_AAAA, 1'b0, 1'b0));
    foreach (ops[k]) begin
      apply(ops[k]);
      @(negedge clk);
      x = sb.pop_front();
      total++;
      if (memReadData !== x.d || bus_err !== x.e || irq !== x.i) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got d=%h err=%b irq=%b want d=%h err=%b irq=%b",
                 k, memReadData, bus_err, irq, x.d, x.e, x.i);
      end
      tick;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ram;
    test_bus_err;
`ifdef DMEM_TIMER_EN
    test_timer_irq;
    test_autoreload;
    test_wrap;
`else
    test_no_timer;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

endmodule
